// File: rtl/bcd_fib_inv.sv
// Inverse Fibonacci with BCD I/O: finds the smallest n such that fib(n) >= v for v = 0..9999.
// Flow: BCD-to-binary accumulation (4 cycles), iterative Fibonacci search, index-to-BCD.
module bcd_fib_inv (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic       ready,
  output logic       done_tick,
  output logic [3:0] out_bcd1,
  output logic [3:0] out_bcd0
);

  // Handshake: start is sampled only while ready=1 (idle); a request seen then
  // is latched with its digits. done_tick pulses for one cycle when out_bcd1/0
  // take the new result. start while ready=0 is dropped, never queued.
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SEARCH, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] dig_q, dig_d;
  logic [13:0] bin_q, bin_d;
  logic [1:0]  k_q, k_d;
  logic [14:0] t0_q, t0_d, t1_q, t1_d;
  logic [4:0]  n_q, n_d;
  logic [3:0]  o1_d, o0_d;

  logic [3:0]  cur_dig;
  logic [13:0] bin_x10;
  logic [1:0]  tens;
  logic [4:0]  units;
  logic        bad_digit;

  always_comb begin
    cur_dig = dig_q[15:12];
    case (k_q)
      2'd0: cur_dig = dig_q[15:12];
      2'd1: cur_dig = dig_q[11:8];
      2'd2: cur_dig = dig_q[7:4];
      2'd3: cur_dig = dig_q[3:0];
      default: cur_dig = dig_q[15:12];
    endcase
  end

  assign bin_x10   = {bin_q[10:0], 3'b000} + {bin_q[12:0], 1'b0};
  assign bad_digit = (bcd3 > 4'd9) || (bcd2 > 4'd9) || (bcd1 > 4'd9) || (bcd0 > 4'd9);

  // n never exceeds 21, so the tens digit is at most 2.
  always_comb begin
    tens = 2'd0;
    if (n_q >= 5'd20)      tens = 2'd2;
    else if (n_q >= 5'd10) tens = 2'd1;
    units = n_q - ((tens == 2'd2) ? 5'd20 : (tens == 2'd1) ? 5'd10 : 5'd0);
  end

  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    bin_d     = bin_q;
    k_d       = k_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    n_d       = n_q;
    o1_d      = out_bcd1;
    o0_d      = out_bcd0;
    ready     = 1'b0;
    done_tick = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          dig_d = {bcd3, bcd2, bcd1, bcd0};
          if (bad_digit) begin
            o1_d    = 4'd9;
            o0_d    = 4'd9;
            state_d = S_DONE;
          end else begin
            bin_d   = 14'd0;
            k_d     = 2'd0;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        bin_d = bin_x10 + {10'd0, cur_dig};
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) begin
          t0_d    = 15'd0;
          t1_d    = 15'd1;
          n_d     = 5'd0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (t0_q >= {1'b0, bin_q}) begin
          o1_d    = {2'b00, tens};
          o0_d    = units[3:0];
          state_d = S_DONE;
        end else begin
          t0_d = t1_q;
          t1_d = t0_q + t1_q;
          n_d  = n_q + 5'd1;
        end
      end
      S_DONE: begin
        done_tick = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dig_q    <= '0;
      bin_q    <= '0;
      k_q      <= '0;
      t0_q     <= '0;
      t1_q     <= '0;
      n_q      <= '0;
      out_bcd1 <= '0;
      out_bcd0 <= '0;
    end else begin
      state_q  <= state_d;
      dig_q    <= dig_d;
      bin_q    <= bin_d;
      k_q      <= k_d;
      t0_q     <= t0_d;
      t1_q     <= t1_d;
      n_q      <= n_d;
      out_bcd1 <= o1_d;
      out_bcd0 <= o0_d;
    end
  end

endmodule

// File: tb/tb_bcd_fib_inv.sv
// Bench for bcd_fib_inv: directed vector table, handshake/reset sequences, strided sweep vs a Fibonacci table.
module tb_bcd_fib_inv;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
  logic       ready, done_tick;
  logic [3:0] out_bcd1, out_bcd0;

  int total = 0;
  int bad = 0;
  logic [3:0] prev1 = '0, prev0 = '0;
  int fib [0:22];

  typedef struct {
    logic [3:0] d3, d2, d1, d0;
    logic [3:0] e1, e0;
    int         lat;
    string      name;
  } vec_t;

  vec_t vecs [12];

  bcd_fib_inv dut (
    .clk(clk), .reset(reset), .start(start),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .ready(ready), .done_tick(done_tick),
    .out_bcd1(out_bcd1), .out_bcd0(out_bcd0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One operation: start in cycle 0, optional ignored start pulses at cycles 2 and 7,
  // digits scrambled after cycle 0, outputs must hold until done_tick.
  task automatic run_op(input logic [3:0] a, b, c, d, input logic [3:0] e1, e0,
                        input int lat, input bit noise, input string name);
    int  cnt;
    bit  got;
    bit  moved;
    @(posedge clk); #1;
    chk({name, " ready_before"}, int'(ready), 1);
    bcd3 = a; bcd2 = b; bcd1 = c; bcd0 = d;
    start = 1'b1;
    cnt = 0; got = 0; moved = 0;
    while (!got && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      start = noise && (cnt == 2 || cnt == 7);
      bcd3 = 4'($urandom_range(0, 15)); bcd2 = 4'($urandom_range(0, 15));
      bcd1 = 4'($urandom_range(0, 15)); bcd0 = 4'($urandom_range(0, 15));
      if (done_tick) got = 1;
      else if (out_bcd1 != prev1 || out_bcd0 != prev0) moved = 1;
    end
    start = 1'b0;
    chk({name, " done_seen"}, int'(got), 1);
    chk({name, " latency"}, cnt, lat);
    chk({name, " out"}, int'({out_bcd1, out_bcd0}), int'({e1, e0}));
    chk({name, " held"}, int'(moved), 0);
    prev1 = e1; prev0 = e0;
    @(posedge clk); #1;
    chk({name, " one_tick"}, int'({done_tick, ready}), 1);
  endtask

  function automatic int ref_n(input int v);
    for (int i = 0; i <= 22; i++) if (fib[i] >= v) return i;
    return 99;
  endfunction

  task automatic run_val(input int v, input bit noise);
    int n;
    n = ref_n(v);
    run_op(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10),
           4'(n / 10), 4'(n % 10), n + 6, noise, $sformatf("v=%0d", v));
  endtask

  initial begin
    int d1c, d2c, cnt;
    fib[0] = 0; fib[1] = 1;
    for (int i = 2; i <= 22; i++) fib[i] = fib[i-1] + fib[i-2];

    vecs[0]  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 6,  "v0000"};
    vecs[1]  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 7,  "v0001"};
    vecs[2]  = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd3, 9,  "v0002"};
    vecs[3]  = '{4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd5, 11, "v0005"};
    vecs[4]  = '{4'd0, 4'd0, 4'd0, 4'd6, 4'd0, 4'd6, 12, "v0006"};
    vecs[5]  = '{4'd6, 4'd7, 4'd6, 4'd5, 4'd2, 4'd0, 26, "v6765"};
    vecs[6]  = '{4'd6, 4'd7, 4'd6, 4'd6, 4'd2, 4'd1, 27, "v6766"};
    vecs[7]  = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd2, 4'd1, 27, "v9999"};
    vecs[8]  = '{4'd0, 4'd0, 4'd8, 4'd9, 4'd1, 4'd1, 17, "v0089"};
    vecs[9]  = '{4'd0, 4'd0, 4'd9, 4'd0, 4'd1, 4'd2, 18, "v0090"};
    vecs[10] = '{4'd0, 4'd10, 4'd1, 4'd2, 4'd9, 4'd9, 1, "v0A12"};
    vecs[11] = '{4'd0, 4'd1, 4'd4, 4'd4, 4'd1, 4'd2, 18, "v0144"};

    #12;
    chk("reset_ready", int'(ready), 1);
    chk("reset_done", int'(done_tick), 0);
    chk("reset_out", int'({out_bcd1, out_bcd0}), 0);
    reset = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0,
             vecs[i].e1, vecs[i].e0, vecs[i].lat, 1'b0, vecs[i].name);

    // Extra start pulses during conv and search must not disturb the first request.
    run_op(4'd0, 4'd0, 4'd8, 4'd9, 4'd1, 4'd1, 17, 1'b1, "ignore_start");

    // Reset in the middle of a search aborts with no done_tick and clears outputs.
    @(posedge clk); #1;
    bcd3 = 4'd9; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_out", int'({out_bcd1, out_bcd0}), 0);
    chk("abort_done", int'(done_tick), 0);
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_ready", int'(ready), 1);
    cnt = 0;
    repeat (30) begin @(posedge clk); #1; if (done_tick) cnt++; end
    chk("abort_no_tick", cnt, 0);
    prev1 = '0; prev0 = '0;

    // start held high: v=0 completes in cycle 6, restarts in cycle 7, completes in cycle 13.
    @(posedge clk); #1;
    bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0; start = 1'b1;
    d1c = -1; d2c = -1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (done_tick) begin
        if (d1c < 0) d1c = c; else if (d2c < 0) d2c = c;
      end
    end
    start = 1'b0;
    chk("b2b_first", d1c, 6);
    chk("b2b_second", d2c, 13);
    repeat (8) @(posedge clk);

    // Fibonacci boundaries and a strided sweep against the table model.
    for (int i = 2; i <= 20; i++) begin
      run_val(fib[i], 1'b0);
      run_val(fib[i] + 1, 1'b0);
    end
    for (int v = 0; v <= 9999; v += 97) run_val(v, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
